// File: rtl/ssi_angle_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ssi_angle_tracker                                             |
// | Desc     : Multi-turn unwrapping of SSI absolute angle words, with jump  |
// |            rejection, magnet fault latching and windowed velocity.       |
// |            Optional ANGLE_DEGLITCH_EN: median-of-3 filter on samples.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ssi_angle_tracker #(
    parameter int SSI_RES           = 10,
    parameter int TURN_BITS         = 16,
    parameter int MAX_STEP          = 256,
    parameter int REJECT_LIMIT      = 3,
    parameter int VEL_WINDOW_CYCLES = 5_000_000,
    localparam int POS_W            = SSI_RES + TURN_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SSI_RES-1:0] angle_in,
    input  logic               angle_valid,
    input  logic               mag_high,
    input  logic               mag_low,
    input  logic               zero_req,
    output logic [POS_W-1:0]   position,
    output logic               pos_valid,
    output logic [POS_W-1:0]   velocity,
    output logic               vel_valid,
    output logic               fault,
    output logic [1:0]         fault_code
);

    localparam int C_REJ_W = (REJECT_LIMIT > 1) ? $clog2(REJECT_LIMIT + 1) : 1;
    localparam int C_CNT_W = (VEL_WINDOW_CYCLES > 1) ? $clog2(VEL_WINDOW_CYCLES) : 1;
    localparam logic [SSI_RES:0]   C_MAX_STEP  = (SSI_RES + 1)'(MAX_STEP);
    localparam logic [C_REJ_W-1:0] C_REJ_LIMIT = C_REJ_W'(REJECT_LIMIT);
    localparam logic [C_CNT_W-1:0] C_WIN_LAST  = C_CNT_W'(VEL_WINDOW_CYCLES - 1);
    localparam logic [1:0]         C_CODE_NONE = 2'b00;
    localparam logic [1:0]         C_CODE_MAG  = 2'b01;
    localparam logic [1:0]         C_CODE_JUMP = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [POS_W-1:0]     r_position, w_position_nxt;
    logic [SSI_RES-1:0]   r_last_angle, w_last_nxt;
    logic [C_REJ_W-1:0]   r_rej_cnt, w_rej_nxt, w_rej_inc;
    logic [1:0]           r_fault_code, w_code_nxt;
    logic [POS_W-1:0]     w_vel_delta;
    logic [C_CNT_W-1:0]   r_win_cnt;
    logic [POS_W-1:0]     r_accum, r_velocity;
    logic                 r_vel_valid;

    logic                 w_accept, w_mag_evt;
    logic                 w_smp_valid;
    logic [SSI_RES-1:0]   w_smp_angle;
    logic signed [SSI_RES-1:0] w_delta;
    logic signed [SSI_RES:0]   w_delta_wide;
    logic [SSI_RES:0]     w_abs;
    logic                 w_step_ok;
    logic [POS_W-1:0]     w_delta_ext;
    logic                 w_win_end;

    assign w_accept  = angle_valid & ~mag_high & ~mag_low;
    assign w_mag_evt = angle_valid & (mag_high | mag_low);

`ifdef ANGLE_DEGLITCH_EN
    // Median is taken over deltas relative to the oldest sample so the wrap
    // point of the raw angle never confuses the ordering.
    logic [SSI_RES-1:0]        r_hist0, r_hist1;
    logic [1:0]                r_fill;
    logic signed [SSI_RES-1:0] w_d1, w_d2, w_lo, w_hi, w_med;

    always_comb begin
        w_d1 = $signed(r_hist1 - r_hist0);
        w_d2 = $signed(angle_in - r_hist0);
        w_lo = (w_d1 < w_d2) ? w_d1 : w_d2;
        w_hi = (w_d1 < w_d2) ? w_d2 : w_d1;
        if (w_hi[SSI_RES-1])
            w_med = w_hi;
        else if (!w_lo[SSI_RES-1] && (|w_lo))
            w_med = w_lo;
        else
            w_med = '0;
    end

    assign w_smp_valid = w_accept && (r_fill == 2'd2);
    assign w_smp_angle = r_hist0 + $unsigned(w_med);

    always_ff @(posedge clk) begin
        if (rst || r_state == ST_FAULT) begin
            r_hist0 <= '0;
            r_hist1 <= '0;
            r_fill  <= 2'd0;
        end else if (zero_req) begin
            r_hist0 <= angle_in;
            r_hist1 <= angle_in;
            r_fill  <= w_accept ? 2'd2 : 2'd0;
        end else if (w_accept) begin
            r_hist0 <= r_hist1;
            r_hist1 <= angle_in;
            if (r_fill != 2'd2)
                r_fill <= r_fill + 2'd1;
        end
    end
`else
    assign w_smp_valid = w_accept;
    assign w_smp_angle = angle_in;
`endif

    assign w_delta      = $signed(w_smp_angle - r_last_angle);
    assign w_delta_wide = {w_delta[SSI_RES-1], w_delta};
    assign w_abs        = w_delta_wide[SSI_RES] ? -w_delta_wide : w_delta_wide;
    assign w_step_ok    = (w_abs <= C_MAX_STEP);
    assign w_delta_ext  = {{TURN_BITS{w_delta[SSI_RES-1]}}, w_delta};
    assign w_rej_inc    = r_rej_cnt + C_REJ_W'(1);
    assign w_win_end    = (r_win_cnt == C_WIN_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_position_nxt = r_position;
        w_last_nxt     = r_last_angle;
        w_rej_nxt      = r_rej_cnt;
        w_code_nxt     = r_fault_code;
        w_vel_delta    = '0;
        case (r_state)
            ST_INIT: begin
                if (zero_req)
                    w_position_nxt = '0;
                // Magnet-flagged samples are simply ignored until tracking starts.
                if (w_smp_valid) begin
                    w_state_nxt    = ST_TRACK;
                    w_last_nxt     = w_smp_angle;
                    w_position_nxt = '0;
                    w_rej_nxt      = '0;
                end
            end
            ST_TRACK: begin
                if (zero_req) begin
                    w_position_nxt = '0;
                    w_rej_nxt      = '0;
                    if (w_accept)
                        w_last_nxt = angle_in;
                end else if (w_mag_evt) begin
                    w_state_nxt = ST_FAULT;
                    w_code_nxt  = C_CODE_MAG;
                    w_rej_nxt   = '0;
                end else if (w_smp_valid) begin
                    if (w_step_ok) begin
                        w_position_nxt = r_position + w_delta_ext;
                        w_last_nxt     = w_smp_angle;
                        w_rej_nxt      = '0;
                        w_vel_delta    = w_delta_ext;
                    end else if (w_rej_inc >= C_REJ_LIMIT) begin
                        w_state_nxt = ST_FAULT;
                        w_code_nxt  = C_CODE_JUMP;
                        w_rej_nxt   = '0;
                    end else begin
                        w_rej_nxt = w_rej_inc;
                    end
                end
            end
            ST_FAULT: begin
                if (zero_req) begin
                    w_state_nxt    = ST_INIT;
                    w_position_nxt = '0;
                    w_code_nxt     = C_CODE_NONE;
                    w_rej_nxt      = '0;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_position   <= '0;
            r_last_angle <= '0;
            r_rej_cnt    <= '0;
            r_fault_code <= C_CODE_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_position   <= w_position_nxt;
            r_last_angle <= w_last_nxt;
            r_rej_cnt    <= w_rej_nxt;
            r_fault_code <= w_code_nxt;
        end
    end

    // The delta applied on the window's last cycle belongs to that window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt   <= '0;
            r_accum     <= '0;
            r_velocity  <= '0;
            r_vel_valid <= 1'b0;
        end else if (w_win_end) begin
            r_win_cnt   <= '0;
            r_accum     <= '0;
            r_velocity  <= r_accum + w_vel_delta;
            r_vel_valid <= 1'b1;
        end else begin
            r_win_cnt   <= r_win_cnt + C_CNT_W'(1);
            r_accum     <= r_accum + w_vel_delta;
            r_vel_valid <= 1'b0;
        end
    end

    assign position   = r_position;
    assign pos_valid  = (r_state == ST_TRACK);
    assign fault      = (r_state == ST_FAULT);
    assign fault_code = r_fault_code;
    assign velocity   = r_velocity;
    assign vel_valid  = r_vel_valid;

endmodule
`default_nettype wire

// File: tb/tb_ssi_angle_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ssi_angle_tracker                                          |
// | Desc     : Scoreboard bench for ssi_angle_tracker (1000-cycle windows).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ssi_angle_tracker;

    localparam int POS_W = 26;
    localparam int WIN   = 1000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [9:0]       angle_in = '0;
    logic             angle_valid = 1'b0, mag_high = 1'b0, mag_low = 1'b0, zero_req = 1'b0;
    logic [POS_W-1:0] position, velocity;
    logic             pos_valid, vel_valid, fault;
    logic [1:0]       fault_code;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [POS_W-1:0] pos;
        logic             pv;
        logic             flt;
        logic [1:0]       code;
    } exp_t;

    // av, angle, mag_high, mag_low, zero_req -> expected pos, pos_valid, fault, code
    typedef struct {
        int av; int ang; int mh; int ml; int zr;
        int pos; int pv; int flt; int code;
    } row_t;

    exp_t             sb[$];
    logic [POS_W-1:0] vel_sb[$];

    always #5 clk = ~clk;

    ssi_angle_tracker #(
        .SSI_RES(10), .TURN_BITS(16), .MAX_STEP(256),
        .REJECT_LIMIT(3), .VEL_WINDOW_CYCLES(WIN)
    ) dut (
        .clk(clk), .rst(rst), .angle_in(angle_in), .angle_valid(angle_valid),
        .mag_high(mag_high), .mag_low(mag_low), .zero_req(zero_req),
        .position(position), .pos_valid(pos_valid), .velocity(velocity),
        .vel_valid(vel_valid), .fault(fault), .fault_code(fault_code)
    );

    task automatic step(input logic av, input logic [9:0] a, input logic mh,
                        input logic ml, input logic zr);
        angle_valid = av; angle_in = a; mag_high = mh; mag_low = ml; zero_req = zr;
        @(posedge clk); #1;
        angle_valid = 1'b0; mag_high = 1'b0; mag_low = 1'b0; zero_req = 1'b0;
    endtask

    function automatic void push_row(input row_t r);
        exp_t e;
        e.pos = POS_W'(r.pos); e.pv = 1'(r.pv); e.flt = 1'(r.flt); e.code = 2'(r.code);
        sb.push_back(e);
    endfunction

    task automatic test_reset();
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        push_row('{0, 0, 0, 0, 0, 0, 0, 0, 0});
        e = sb.pop_front();
        n_cmp++;
        if ({position, pos_valid, fault, fault_code, velocity, vel_valid} !==
            {e.pos, e.pv, e.flt, e.code, POS_W'(0), 1'b0}) begin
            n_err++;
            $display("FAIL reset: got pos=%0d pv=%b fault=%b code=%b vel=%0d vv=%b, want all zero",
                     $signed(position), pos_valid, fault, fault_code, $signed(velocity), vel_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_init();
        row_t tbl[2] = '{'{1, 100, 0, 0, 0, 0, 1, 0, 0}, '{0, 0, 0, 0, 0, 0, 1, 0, 0}};
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            push_row(tbl[i]);
            step(1'(tbl[i].av), 10'(tbl[i].ang), 1'(tbl[i].mh), 1'(tbl[i].ml), 1'(tbl[i].zr));
            e = sb.pop_front();
            n_cmp++;
            if ({position, pos_valid, fault, fault_code} !== {e.pos, e.pv, e.flt, e.code}) begin
                n_err++;
                $display("FAIL init[%0d]: got pos=%0d pv=%b fault=%b code=%b, want pos=%0d pv=%b fault=%b code=%b",
                         i, $signed(position), pos_valid, fault, fault_code, $signed(e.pos), e.pv, e.flt, e.code);
            end
        end
    endtask

    // Wrap across 0/1023, +/-256 boundary accepted, 258 rejected, reject count cleared.
    task automatic test_track();
        row_t tbl[10] = '{
            '{1, 1020, 0, 0, 0, -104, 1, 0, 0}, '{1,    4, 0, 0, 0,  -96, 1, 0, 0},
            '{1,    4, 0, 0, 0,  -96, 1, 0, 0}, '{1, 1020, 0, 0, 0, -104, 1, 0, 0},
            '{1,    4, 0, 0, 0,  -96, 1, 0, 0}, '{1,  260, 0, 0, 0,  160, 1, 0, 0},
            '{1,    4, 0, 0, 0,  -96, 1, 0, 0}, '{1,  262, 0, 0, 0,  -96, 1, 0, 0},
            '{1,  262, 0, 0, 0,  -96, 1, 0, 0}, '{1,   10, 0, 0, 0,  -90, 1, 0, 0}};
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            push_row(tbl[i]);
            step(1'(tbl[i].av), 10'(tbl[i].ang), 1'(tbl[i].mh), 1'(tbl[i].ml), 1'(tbl[i].zr));
            e = sb.pop_front();
            n_cmp++;
            if ({position, pos_valid, fault, fault_code} !== {e.pos, e.pv, e.flt, e.code}) begin
                n_err++;
                $display("FAIL track[%0d]: got pos=%0d pv=%b fault=%b code=%b, want pos=%0d pv=%b fault=%b code=%b",
                         i, $signed(position), pos_valid, fault, fault_code, $signed(e.pos), e.pv, e.flt, e.code);
            end
        end
    endtask

    task automatic test_jump_fault();
        row_t tbl[4] = '{
            '{1, 100, 0, 0, 0, 0, 1, 0, 0}, '{1, 600, 0, 0, 0, 0, 1, 0, 0},
            '{1, 600, 0, 0, 0, 0, 1, 0, 0}, '{1, 600, 0, 0, 0, 0, 0, 1, 2}};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            push_row(tbl[i]);
            step(1'(tbl[i].av), 10'(tbl[i].ang), 1'(tbl[i].mh), 1'(tbl[i].ml), 1'(tbl[i].zr));
            e = sb.pop_front();
            n_cmp++;
            if ({position, pos_valid, fault, fault_code} !== {e.pos, e.pv, e.flt, e.code}) begin
                n_err++;
                $display("FAIL jump[%0d]: got pos=%0d pv=%b fault=%b code=%b, want pos=%0d pv=%b fault=%b code=%b",
                         i, $signed(position), pos_valid, fault, fault_code, $signed(e.pos), e.pv, e.flt, e.code);
            end
        end
    endtask

    // Fault is sticky, zero_req recovers, magnet in TRACK faults, magnet in INIT is ignored.
    task automatic test_fault_magnet();
        row_t tbl[9] = '{
            '{1, 120, 0, 0, 0,  0, 0, 1, 2}, '{1, 130, 1, 0, 0,  0, 0, 1, 2},
            '{0,   0, 0, 0, 1,  0, 0, 0, 0}, '{1, 200, 0, 0, 0,  0, 1, 0, 0},
            '{1, 210, 0, 0, 0, 10, 1, 0, 0}, '{1, 220, 0, 1, 0, 10, 0, 1, 1},
            '{0,   0, 0, 0, 1,  0, 0, 0, 0}, '{1, 150, 1, 0, 0,  0, 0, 0, 0},
            '{1,   0, 0, 0, 0,  0, 1, 0, 0}};
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            push_row(tbl[i]);
            step(1'(tbl[i].av), 10'(tbl[i].ang), 1'(tbl[i].mh), 1'(tbl[i].ml), 1'(tbl[i].zr));
            e = sb.pop_front();
            n_cmp++;
            if ({position, pos_valid, fault, fault_code} !== {e.pos, e.pv, e.flt, e.code}) begin
                n_err++;
                $display("FAIL fault_mag[%0d]: got pos=%0d pv=%b fault=%b code=%b, want pos=%0d pv=%b fault=%b code=%b",
                         i, $signed(position), pos_valid, fault, fault_code, $signed(e.pos), e.pv, e.flt, e.code);
            end
        end
    endtask

    task automatic test_zero();
        row_t tbl[8] = '{
            '{1, 250, 0, 0, 0, 250, 1, 0, 0}, '{1, 500, 0, 0, 0, 500, 1, 0, 0},
            '{1, 750, 0, 0, 0, 750, 1, 0, 0}, '{1, 777, 0, 0, 0, 777, 1, 0, 0},
            '{1, 300, 0, 0, 1,   0, 1, 0, 0}, '{1, 310, 0, 0, 0,  10, 1, 0, 0},
            '{0,   0, 0, 0, 1,   0, 1, 0, 0}, '{1, 320, 0, 0, 0,  10, 1, 0, 0}};
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            push_row(tbl[i]);
            step(1'(tbl[i].av), 10'(tbl[i].ang), 1'(tbl[i].mh), 1'(tbl[i].ml), 1'(tbl[i].zr));
            e = sb.pop_front();
            n_cmp++;
            if ({position, pos_valid, fault, fault_code} !== {e.pos, e.pv, e.flt, e.code}) begin
                n_err++;
                $display("FAIL zero[%0d]: got pos=%0d pv=%b fault=%b code=%b, want pos=%0d pv=%b fault=%b code=%b",
                         i, $signed(position), pos_valid, fault, fault_code, $signed(e.pos), e.pv, e.flt, e.code);
            end
        end
    endtask

    // Starts from last angle 320 in TRACK.
    task automatic test_velocity();
        logic [POS_W-1:0] v;
        // align to a window boundary
        for (int k = 0; k < WIN + 10; k++) begin
            @(posedge clk); #1;
            if (vel_valid) break;
        end
        n_cmp++;
        if (vel_valid !== 1'b1) begin
            n_err++;
            $display("FAIL vel_sync: got vel_valid=%b, want 1 within %0d cycles", vel_valid, WIN + 10);
        end
        // ten +5 deltas in one window
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 10'(320 + 5 * i), 1'b0, 1'b0, 1'b0);
        end
        vel_sb.push_back(POS_W'(50));
        for (int k = 0; k < WIN + 10; k++) begin
            @(posedge clk); #1;
            if (vel_valid) break;
        end
        v = vel_sb.pop_front();
        n_cmp++;
        if (vel_valid !== 1'b1 || velocity !== v) begin
            n_err++;
            $display("FAIL vel_window: got vel_valid=%b velocity=%0d, want vel_valid=1 velocity=%0d",
                     vel_valid, $signed(velocity), $signed(v));
        end
        // a +7 delta landing on the window's last cycle
        vel_sb.push_back(POS_W'(7));
        repeat (WIN - 1) @(posedge clk);
        #1;
        step(1'b1, 10'd377, 1'b0, 1'b0, 1'b0);
        v = vel_sb.pop_front();
        n_cmp++;
        if (vel_valid !== 1'b1 || velocity !== v) begin
            n_err++;
            $display("FAIL vel_last_cycle: got vel_valid=%b velocity=%0d, want vel_valid=1 velocity=%0d",
                     vel_valid, $signed(velocity), $signed(v));
        end
        @(posedge clk); #1;
        n_cmp++;
        if (vel_valid !== 1'b0) begin
            n_err++;
            $display("FAIL vel_pulse_width: got vel_valid=%b, want 0", vel_valid);
        end
        // empty window
        vel_sb.push_back(POS_W'(0));
        for (int k = 0; k < WIN + 10; k++) begin
            @(posedge clk); #1;
            if (vel_valid) break;
        end
        v = vel_sb.pop_front();
        n_cmp++;
        if (vel_valid !== 1'b1 || velocity !== v) begin
            n_err++;
            $display("FAIL vel_empty: got vel_valid=%b velocity=%0d, want vel_valid=1 velocity=%0d",
                     vel_valid, $signed(velocity), $signed(v));
        end
        n_cmp++;
        if (position !== POS_W'(67) || pos_valid !== 1'b1) begin
            n_err++;
            $display("FAIL vel_position: got pos=%0d pv=%b, want pos=67 pv=1", $signed(position), pos_valid);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_track();
        test_jump_fault();
        test_fault_magnet();
        test_zero();
        test_velocity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
